// File: rtl/rwf_pkg.sv
// Shared types and default sizing for the windowed register file.
package rwf_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } rwf_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NWIN   = 4;
  localparam int DEF_WREGS  = 8;

endpackage

// File: rtl/rwf_win_ptr.sv
// Window pointer with saturating call/return and one-cycle reject flags.
module rwf_win_ptr #(
  parameter int NWIN = 4,
  parameter int PW   = $clog2(NWIN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          enable,
  output logic [PW-1:0] cwp,
  output logic          ovf,
  output logic          unf
);

  localparam logic [PW-1:0] TOP = PW'(NWIN - 1);

  // Simultaneous inc and dec cancel out without raising either flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cwp <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= 1'b0;
      unf <= 1'b0;
      if (enable && inc && !dec) begin
        if (cwp == TOP) ovf <= 1'b1;
        else            cwp <= cwp + 1'b1;
      end else if (enable && dec && !inc) begin
        if (cwp == '0) unf <= 1'b1;
        else           cwp <= cwp - 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_window_file.sv
// Windowed register file: two combinational read ports, one write port,
// a movable window pointer and a multi-cycle clear of the current window.
module reg_window_file
  import rwf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NWIN   = DEF_NWIN,
  parameter int WREGS  = DEF_WREGS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(WREGS)-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]          rd_data_a,
  input  logic [$clog2(WREGS)-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]          rd_data_b,
  input  logic                       wr_en,
  input  logic [$clog2(WREGS)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       win_inc,
  input  logic                       win_dec,
  input  logic                       win_clr,
  output logic [$clog2(NWIN)-1:0]    cwp,
  output logic                       busy,
  output logic                       win_ovf,
  output logic                       win_unf
);

  localparam int AW    = $clog2(WREGS);
  localparam int PW    = $clog2(NWIN);
  localparam int WORDS = NWIN * WREGS;

  rwf_state_t         state, state_next;
  logic [AW-1:0]      clr_idx;
  logic [PW-1:0]      clr_win;
  logic               accept;
  logic [DATA_W-1:0]  mem [WORDS];

  // Ordinary operations are only taken in IDLE and only when no clear is requested.
  assign accept = (state == IDLE) && !win_clr;
  assign busy   = (state == CLEAR);

  rwf_win_ptr #(
    .NWIN (NWIN),
    .PW   (PW)
  ) u_win_ptr (
    .clk    (clk),
    .rst    (rst),
    .inc    (win_inc),
    .dec    (win_dec),
    .enable (accept),
    .cwp    (cwp),
    .ovf    (win_ovf),
    .unf    (win_unf)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_clr) state_next = CLEAR;
      CLEAR:   if (clr_idx == AW'(WREGS - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      clr_idx <= '0;
      clr_win <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && win_clr) begin
        clr_idx <= '0;
        clr_win <= cwp;
      end else if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
      end
    end
  end

  // Word address is {window, index}, so clearing the latched window cannot touch others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[{clr_win, clr_idx}] <= '0;
    end else if (accept && wr_en) begin
      mem[{cwp, wr_addr}] <= wr_data;
    end
  end

  assign rd_data_a = mem[{cwp, rd_addr_a}];
  assign rd_data_b = mem[{cwp, rd_addr_b}];

endmodule

// File: tb/tb_reg_window_file.sv
// Directed self-checking bench for reg_window_file (NWIN=4, WREGS=8, DATA_W=16).
module tb_reg_window_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] rd_data_a, rd_data_b, wr_data;
  logic        wr_en, win_inc, win_dec, win_clr;
  logic [1:0]  cwp;
  logic        busy, win_ovf, win_unf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_window_file #(.DATA_W(16), .NWIN(4), .WREGS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .win_inc   (win_inc),
    .win_dec   (win_dec),
    .win_clr   (win_clr),
    .cwp       (cwp),
    .busy      (busy),
    .win_ovf   (win_ovf),
    .win_unf   (win_unf)
  );

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rd_addr_a = 3'd3;
    rd_addr_b = 3'd7;
    #1;
    n_checks++;
    if (cwp !== 2'd0 || busy !== 1'b0 || win_ovf !== 1'b0 || win_unf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl got cwp=%0d busy=%b ovf=%b unf=%b want 0 0 0 0", cwp, busy, win_ovf, win_unf);
    end
    n_checks++;
    if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL reset_data got a=%h b=%h want 0000 0000", rd_data_a, rd_data_b);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_window_isolation();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    rd_addr_a = 3'd3;
    #1;
    n_checks++;
    if (rd_data_a !== 16'h1234) begin
      n_fail++;
      $display("[TB] FAIL iso_write got %h want 1234", rd_data_a);
    end
    win_inc = 1'b1;
    tick();
    win_inc = 1'b0;
    #1;
    n_checks++;
    if (cwp !== 2'd1 || rd_data_a !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL iso_inc got cwp=%0d r3=%h want 1 0000", cwp, rd_data_a);
    end
    win_dec = 1'b1;
    tick();
    win_dec = 1'b0;
    rd_addr_b = 3'd3;
    #1;
    n_checks++;
    if (cwp !== 2'd0 || rd_data_a !== 16'h1234 || rd_data_b !== 16'h1234) begin
      n_fail++;
      $display("[TB] FAIL iso_dec got cwp=%0d a=%h b=%h want 0 1234 1234", cwp, rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_ovf_unf();
    logic [1:0] exp_cwp;
    logic       exp_ovf;
    for (int i = 0; i < 4; i++) begin
      win_inc = 1'b1;
      tick();
      exp_cwp = (i < 3) ? 2'(i + 1) : 2'd3;
      exp_ovf = (i == 3);
      n_checks++;
      if (cwp !== exp_cwp || win_ovf !== exp_ovf || win_unf !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL ovf_step%0d got cwp=%0d ovf=%b unf=%b want %0d %b 0", i, cwp, win_ovf, win_unf, exp_cwp, exp_ovf);
      end
    end
    win_inc = 1'b0;
    tick();
    n_checks++;
    if (cwp !== 2'd3 || win_ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ovf_pulse_end got cwp=%0d ovf=%b want 3 0", cwp, win_ovf);
    end
    win_dec = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (cwp !== 2'd0 || win_unf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL unf_descend got cwp=%0d unf=%b want 0 0", cwp, win_unf);
    end
    tick();
    n_checks++;
    if (cwp !== 2'd0 || win_unf !== 1'b1 || win_ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL unf_reject got cwp=%0d unf=%b ovf=%b want 0 1 0", cwp, win_unf, win_ovf);
    end
    win_dec = 1'b0;
    tick();
    n_checks++;
    if (win_unf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL unf_pulse_end got %b want 0", win_unf);
    end
  endtask

  task automatic test_inc_dec_together();
    win_inc = 1'b1;
    tick(); tick();
    win_dec = 1'b1;
    tick();
    n_checks++;
    if (cwp !== 2'd2 || win_ovf !== 1'b0 || win_unf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL incdec_both got cwp=%0d ovf=%b unf=%b want 2 0 0", cwp, win_ovf, win_unf);
    end
    win_inc = 1'b0;
    tick();
    win_dec = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; win_inc = 1'b1;
    tick();
    wr_en = 1'b0; win_inc = 1'b0;
    rd_addr_a = 3'd5;
    #1;
    n_checks++;
    if (cwp !== 2'd2 || rd_data_a !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL wr_inc_new got cwp=%0d r5=%h want 2 0000", cwp, rd_data_a);
    end
    win_dec = 1'b1;
    tick();
    win_dec = 1'b0;
    n_checks++;
    if (cwp !== 2'd1 || rd_data_a !== 16'hBEEF) begin
      n_fail++;
      $display("[TB] FAIL wr_inc_old got cwp=%0d r5=%h want 1 beef", cwp, rd_data_a);
    end
  endtask

  task automatic test_clear();
    // cwp=1 on entry; put a marker in window 3, then fill window 2
    win_inc = 1'b1;
    tick(); tick();
    win_inc = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h5555;
    tick();
    wr_en = 1'b0; win_dec = 1'b1;
    tick();
    win_dec = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'hAAAA;
      tick();
    end
    wr_en = 1'b0;
    win_clr = 1'b1;
    tick();
    win_clr = 1'b0;
    win_inc = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
    rd_addr_a = 3'd0; rd_addr_b = 3'd1;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (busy !== 1'b1 || cwp !== 2'd2 || win_ovf !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL clr_busy%0d got busy=%b cwp=%0d ovf=%b want 1 2 0", k, busy, cwp, win_ovf);
      end
      if (k == 1) begin
        n_checks++;
        if (rd_data_a !== 16'h0000 || rd_data_b !== 16'hAAAA) begin
          n_fail++;
          $display("[TB] FAIL clr_partial got r0=%h r1=%h want 0000 aaaa", rd_data_a, rd_data_b);
        end
      end
      tick();
    end
    win_inc = 1'b0; wr_en = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || cwp !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL clr_done got busy=%b cwp=%0d want 0 2", busy, cwp);
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      #1;
      n_checks++;
      if (rd_data_a !== 16'h0000) begin
        n_fail++;
        $display("[TB] FAIL clr_win2_r%0d got %h want 0000", i, rd_data_a);
      end
    end
    rd_addr_a = 3'd5; rd_addr_b = 3'd3;
    win_dec = 1'b1;
    tick();
    n_checks++;
    if (cwp !== 2'd1 || rd_data_a !== 16'hBEEF) begin
      n_fail++;
      $display("[TB] FAIL clr_win1 got cwp=%0d r5=%h want 1 beef", cwp, rd_data_a);
    end
    tick();
    win_dec = 1'b0;
    n_checks++;
    if (cwp !== 2'd0 || rd_data_b !== 16'h1234) begin
      n_fail++;
      $display("[TB] FAIL clr_win0 got cwp=%0d r3=%h want 0 1234", cwp, rd_data_b);
    end
    rd_addr_a = 3'd0; rd_addr_b = 3'd1;
    win_inc = 1'b1;
    tick(); tick(); tick();
    win_inc = 1'b0;
    n_checks++;
    if (cwp !== 2'd3 || rd_data_a !== 16'h5555 || rd_data_b !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL clr_win3 got cwp=%0d r0=%h r1=%h want 3 5555 0000", cwp, rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_reset_during_clear();
    // cwp=3 with r0=0x5555 on entry
    win_clr = 1'b1;
    tick();
    win_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rd_addr_a = 3'd0; rd_addr_b = 3'd1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || cwp !== 2'd0 || rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL rst_clr got busy=%b cwp=%0d a=%h b=%h want 0 0 0000 0000", busy, cwp, rd_data_a, rd_data_b);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_clr_abort got busy=%b want 0", busy);
    end
    rd_addr_a = 3'd3; rd_addr_b = 3'd5;
    #1;
    n_checks++;
    if (rd_data_a !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL rst_win0 got r3=%h want 0000", rd_data_a);
    end
    win_inc = 1'b1;
    tick();
    n_checks++;
    if (cwp !== 2'd1 || rd_data_b !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL rst_win1 got cwp=%0d r5=%h want 1 0000", cwp, rd_data_b);
    end
    rd_addr_a = 3'd0;
    tick(); tick();
    win_inc = 1'b0;
    n_checks++;
    if (cwp !== 2'd3 || rd_data_a !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL rst_win3 got cwp=%0d r0=%h want 3 0000", cwp, rd_data_a);
    end
  endtask

  initial begin
    rst = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    win_inc = 1'b0; win_dec = 1'b0; win_clr = 1'b0;
    test_reset();
    test_window_isolation();
    test_ovf_unf();
    test_inc_dec_together();
    test_clear();
    test_reset_during_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_window_file.md
REG_WINDOW_FILE -- requirements
Module: reg_window_file

Interface
REQ-001 Parameter DATA_W, default 16: register data width in bits.
REQ-002 Parameter NWIN, default 4: number of register windows; power of 2, >= 2.
REQ-003 Parameter WREGS, default 8: registers visible per window; power of 2, >= 2.
REQ-004 Derived widths SHALL be AW = clog2(WREGS) and PW = clog2(NWIN).
REQ-005 Port: clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 Port: rst, input, 1, reset; synchronous, active-low.
REQ-007 Port: rd_addr_a, input, AW, read port A register index within the current window.
REQ-008 Port: rd_data_a, output, DATA_W, read port A data; combinational.
REQ-009 Port: rd_addr_b, input, AW, read port B register index within the current window.
REQ-010 Port: rd_data_b, output, DATA_W, read port B data; combinational.
REQ-011 Port: wr_en, input, 1, write strobe.
REQ-012 Port: wr_addr, input, AW, write index within the current window.
REQ-013 Port: wr_data, input, DATA_W, write data.
REQ-014 Port: win_inc, input, 1, call: advance window pointer.
REQ-015 Port: win_dec, input, 1, return: retreat window pointer.
REQ-016 Port: win_clr, input, 1, zero all registers of the current window.
REQ-017 Port: cwp, output, PW, current window pointer; registered.
REQ-018 Port: busy, output, 1, high while a clear is in progress.
REQ-019 Port: win_ovf, output, 1, one-cycle pulse on rejected win_inc.
REQ-020 Port: win_unf, output, 1, one-cycle pulse on rejected win_dec.

Function
REQ-021 Physical storage: NWIN*WREGS words; logical index i maps to word cwp*WREGS+i.
REQ-022 Reads: combinational from the current cwp; no write bypass, so a write becomes visible the cycle after its edge.
REQ-023 Write: wr_en=1 in IDLE writes wr_data at the edge, using the cwp value before the edge.
REQ-024 win_inc with cwp<NWIN-1: cwp+1 next cycle; with cwp=NWIN-1: cwp holds, win_ovf=1 for one cycle.
REQ-025 win_dec with cwp>0: cwp-1 next cycle; with cwp=0: cwp holds, win_unf=1 for one cycle.
REQ-026 win_inc and win_dec both high: cwp unchanged, no flag asserted.
REQ-027 Write with a simultaneous inc or dec: write targets the old window; pointer change is applied in the same cycle.
REQ-028 FSM states: IDLE, CLEAR.
REQ-029 IDLE to CLEAR when win_clr=1; clear index is set to 0 and the window is latched as the current cwp.
REQ-030 win_clr has priority: wr_en, win_inc and win_dec are ignored in the cycle it is accepted.
REQ-031 CLEAR: writes zero to latched-window index clr_idx each cycle, clr_idx+1; after index WREGS-1 is written, returns to IDLE; total WREGS cycles.
REQ-032 busy=1 exactly in CLEAR.
REQ-033 While busy: wr_en, win_inc, win_dec and win_clr are ignored and no flags are asserted; reads remain live and show partial clear.
REQ-034 Other windows are never modified by a clear.

Reset
REQ-035 rst=0 at an edge: cwp=0, state IDLE, clr_idx=0, busy=0, win_ovf=0, win_unf=0, all storage words 0.
REQ-036 Reset during CLEAR aborts the clear immediately; reset takes priority over every input.
REQ-037 While rst=0, rd_data_a/b reflect zeroed storage from the first post-reset cycle.

Structure
REQ-038 Package rwf_pkg holds the state enum (IDLE, CLEAR) and default parameter constants.
REQ-039 Window pointer and flag logic resides in sub-module rwf_win_ptr (inputs inc, dec, enable; outputs cwp, ovf, unf).

Verification (NWIN=4, WREGS=8, DATA_W=16)
REQ-040 Write 0x1234 to r3 at cwp=0, inc, read r3 -> 0x0000; dec, read r3 -> 0x1234.
REQ-041 Four incs from cwp=0 -> cwp=3, single win_ovf pulse on the 4th; dec at cwp=0 -> win_unf pulse, cwp=0.
REQ-042 inc+dec together at cwp=2 -> cwp=2, no flags; wr_en+inc at cwp=1 -> write lands in window 1.
REQ-043 Fill window 2 with 0xAAAA, clr -> busy high 8 cycles, window 2 reads 0, windows 0/1/3 untouched; inc/wr during busy ignored.
REQ-044 rst=0 on 3rd clear cycle -> next cycle busy=0, cwp=0, all reads 0x0000.
